// File: rtl/request_pkg.sv
// Shared definitions for the request_unit instruction/data bus sequencer:
// FSM state encodings, the reset/abort NOP and data_width encodings.
package request_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_FETCH_REQ  = 3'd1;
    localparam state_t ST_FETCH_WAIT = 3'd2;
    localparam state_t ST_EXEC       = 3'd3;
    localparam state_t ST_DATA_REQ   = 3'd4;
    localparam state_t ST_DATA_WAIT  = 3'd5;
    localparam state_t ST_COMMIT     = 3'd6;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [1:0] DW_BYTE = 2'b00;
    localparam logic [1:0] DW_HALF = 2'b01;
    localparam logic [1:0] DW_WORD = 2'b10;

endpackage

// File: rtl/request_unit_if.sv
// Single-port memory bus between request_unit (master) and memory (slave).
// Strobes and address are held by the master until busy drops.
interface request_unit_if;

    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_read;
    logic        bus_write;
    logic        bus_busy;
    logic        bus_error;

    modport master (
        output bus_addr, bus_wdata, bus_sel,
        output bus_read, bus_write, bus_error,
        input  bus_busy, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_sel,
        input  bus_read, bus_write, bus_error,
        output bus_busy, bus_rdata
    );

endinterface

// File: rtl/request_sel_decode.sv
// Byte-lane decode for data accesses from data_width and address[1:0].
// Halfwords ignore address[0]; the reserved width 2'b11 acts as a word.
module request_sel_decode
    import request_pkg::*;
(
    input  logic [1:0] data_width,
    input  logic [1:0] addr_lo,
    output logic [3:0] sel
);

    // Lane mask selected by access width and low address bits
    always_comb begin
        sel = 4'hF;
        case (data_width)
            DW_BYTE: sel = 4'b0001 << addr_lo;
            DW_HALF: sel = 4'b0011 << {addr_lo[1], 1'b0};
            default: sel = 4'hF;
        endcase
    end

endmodule

// File: rtl/request_unit.sv
// Fetch / one-data-access / commit sequencer between the cpu and the bus.
// Optional macro REQ_TIMEOUT_EN adds a per-wait timeout and sticky bus_error.
module request_unit
    import request_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSN
`ifdef REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_to_mem,
    input  logic [1:0]  data_width,
    output logic [31:0] instruction,
    output logic [31:0] store,
    output logic        pc_enable,
    request_unit_if.master bus
);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] instr_q;
    logic [31:0] store_q;
    logic [3:0]  sel_q;
    logic [3:0]  data_sel;
    logic        read_q;
    logic        write_q;
    logic        unused_pc;

`ifdef REQ_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        error_q;
    logic        timed_out;

    assign timed_out = bus.bus_busy && (wait_cnt == 16'(TIMEOUT - 1));
`endif

    request_sel_decode u_sel (
        .data_width (data_width),
        .addr_lo    (address[1:0]),
        .sel        (data_sel)
    );

    // Sequencer state plus registered bus strobes and cpu-facing latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= NOP;
            store_q <= '0;
            sel_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            wait_cnt <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    read_q  <= 1'b1;
                    write_q <= 1'b0;
                    sel_q   <= 4'hF;
                    state   <= ST_FETCH_REQ;
                end
                ST_FETCH_REQ: begin
                    addr_q <= {pc[31:2], 2'b00};
                    state  <= ST_FETCH_WAIT;
`ifdef REQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_FETCH_WAIT: begin
                    if (!bus.bus_busy) begin
                        instr_q <= bus.bus_rdata;
                        read_q  <= 1'b0;
                        state   <= ST_EXEC;
                    end
`ifdef REQ_TIMEOUT_EN
                    else if (timed_out) begin
                        instr_q <= NOP;
                        read_q  <= 1'b0;
                        error_q <= 1'b1;
                        state   <= ST_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                ST_EXEC: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= {address[31:2], 2'b00};
                        wdata_q <= write_to_mem;
                        sel_q   <= data_sel;
                        write_q <= mem_write;
                        read_q  <= !mem_write;
                        state   <= ST_DATA_REQ;
                    end else begin
                        read_q  <= 1'b1;
                        write_q <= 1'b0;
                        sel_q   <= 4'hF;
                        state   <= ST_FETCH_REQ;
                    end
                end
                ST_DATA_REQ: begin
                    state <= ST_DATA_WAIT;
`ifdef REQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_DATA_WAIT: begin
                    if (!bus.bus_busy) begin
                        if (!write_q) store_q <= bus.bus_rdata;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        state   <= ST_COMMIT;
                    end
`ifdef REQ_TIMEOUT_EN
                    else if (timed_out) begin
                        store_q <= '0;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        error_q <= 1'b1;
                        state   <= ST_COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                ST_COMMIT: begin
                    read_q  <= 1'b1;
                    write_q <= 1'b0;
                    sel_q   <= 4'hF;
                    state   <= ST_FETCH_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The new pc is only valid once FETCH_REQ is entered, so the fetch
    // address passes straight through then and is held from addr_q after.
    assign bus.bus_addr  = (state == ST_FETCH_REQ) ? {pc[31:2], 2'b00} : addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_read  = read_q;
    assign bus.bus_write = write_q;
`ifdef REQ_TIMEOUT_EN
    assign bus.bus_error = error_q;
`else
    assign bus.bus_error = 1'b0;
`endif

    assign pc_enable = (state == ST_COMMIT) ||
                       (state == ST_EXEC && !mem_read && !mem_write);

    assign instruction = instr_q;
    assign store       = store_q;
    assign unused_pc   = ^pc[1:0];

endmodule

// File: tb/tb_request_unit.sv
// Directed testbench for request_unit: reset, fetch, load, store, lanes,
// write priority, reset mid-transaction and (REQ_TIMEOUT_EN) timeout abort.
module tb_request_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_to_mem = '0;
    logic [1:0]  data_width = 2'b10;
    logic [31:0] instruction;
    logic [31:0] store;
    logic        pc_enable;

    int vectors = 0;
    int miscompares = 0;

    request_unit_if bus ();

    request_unit #(
        .NOP(32'h0000_0013)
`ifdef REQ_TIMEOUT_EN
        ,
        .TIMEOUT(4)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .address      (address),
        .write_to_mem (write_to_mem),
        .data_width   (data_width),
        .instruction  (instruction),
        .store        (store),
        .pc_enable    (pc_enable),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    // From a FETCH_REQ negedge: complete the fetch with no wait, land in EXEC
    task automatic to_exec(input logic [31:0] insn);
        mem_read = 1'b0;
        mem_write = 1'b0;
        bus.bus_busy = 1'b0;
        bus.bus_rdata = insn;
        step();
        step();
    endtask

    task automatic test_reset();
        bus.bus_busy = 1'b0;
        bus.bus_rdata = '0;
        reset = 1'b1;
        step();
        step();
        vectors++; if (instruction !== 32'h13) begin miscompares++; $display("FAIL rst_instr got %h want %h", instruction, 32'h13); end
        vectors++; if (store !== 32'h0) begin miscompares++; $display("FAIL rst_store got %h want 0", store); end
        vectors++; if ({pc_enable, bus.bus_read, bus.bus_write, bus.bus_error} !== 4'b0) begin miscompares++; $display("FAIL rst_strobes got %b want 0000", {pc_enable, bus.bus_read, bus.bus_write, bus.bus_error}); end
        vectors++; if ({bus.bus_addr, bus.bus_wdata, bus.bus_sel} !== 68'h0) begin miscompares++; $display("FAIL rst_bus got %h/%h/%h want 0", bus.bus_addr, bus.bus_wdata, bus.bus_sel); end
        reset = 1'b0;
        step();
        vectors++; if ({bus.bus_read, bus.bus_sel} !== 5'b1_1111) begin miscompares++; $display("FAIL rel_fetch rd/sel got %b/%h want 1/f", bus.bus_read, bus.bus_sel); end
        vectors++; if (bus.bus_addr !== 32'h0) begin miscompares++; $display("FAIL rel_addr got %h want 0", bus.bus_addr); end
        bus.bus_busy = 1'b1;
        step();
        vectors++; if (instruction !== 32'h13 || bus.bus_read !== 1'b1) begin miscompares++; $display("FAIL rel_wait instr/rd got %h/%b want 13/1", instruction, bus.bus_read); end
        bus.bus_busy = 1'b0;
        bus.bus_rdata = 32'h0000_0033;
        step();
        vectors++; if (instruction !== 32'h33 || pc_enable !== 1'b1) begin miscompares++; $display("FAIL rel_exec instr/pe got %h/%b want 33/1", instruction, pc_enable); end
        step();
    endtask

    task automatic test_addi();
        int cycles;
        int pulses;
        int first;
        pc = 32'h4;
        bus.bus_busy = 1'b1;
        bus.bus_rdata = 32'h0010_0093;
        #1;
        vectors++; if (bus.bus_addr !== 32'h4) begin miscompares++; $display("FAIL addi_addr got %h want 4", bus.bus_addr); end
        cycles = 1;
        pulses = 0;
        first = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) bus.bus_busy = 1'b0;
            step();
            cycles++;
            if (pc_enable) begin
                pulses++;
                if (first == 0) first = cycles;
            end
        end
        vectors++; if (first !== 5) begin miscompares++; $display("FAIL addi_latency got %0d want 5", first); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL addi_pulses got %0d want 1", pulses); end
        vectors++; if (instruction !== 32'h0010_0093) begin miscompares++; $display("FAIL addi_instr got %h want 00100093", instruction); end
    endtask

    task automatic test_lw();
        pc = 32'h8;
        to_exec(32'h1042_A283);
        vectors++; if (instruction !== 32'h1042_A283) begin miscompares++; $display("FAIL lw_instr got %h want 1042a283", instruction); end
        mem_read = 1'b1;
        address = 32'h104;
        data_width = 2'b10;
        bus.bus_busy = 1'b1;
        bus.bus_rdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (pc_enable !== 1'b0) begin miscompares++; $display("FAIL lw_exec_pe got %b want 0", pc_enable); end
        step();
        vectors++; if ({bus.bus_read, bus.bus_write, bus.bus_sel} !== 6'b10_1111) begin miscompares++; $display("FAIL lw_req rd/wr/sel got %b/%b/%h want 1/0/f", bus.bus_read, bus.bus_write, bus.bus_sel); end
        vectors++; if (bus.bus_addr !== 32'h104) begin miscompares++; $display("FAIL lw_addr got %h want 104", bus.bus_addr); end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if ({pc_enable, bus.bus_read, store} !== {2'b01, 32'h0}) begin miscompares++; $display("FAIL lw_wait pe/rd/store got %b/%b/%h want 0/1/0", pc_enable, bus.bus_read, store); end
        end
        bus.bus_busy = 1'b0;
        step();
        vectors++; if (store !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_store got %h want deadbeef", store); end
        vectors++; if ({pc_enable, bus.bus_read} !== 2'b10) begin miscompares++; $display("FAIL lw_commit pe/rd got %b/%b want 1/0", pc_enable, bus.bus_read); end
        vectors++; if (instruction !== 32'h1042_A283) begin miscompares++; $display("FAIL lw_hold_instr got %h want 1042a283", instruction); end
        step();
        mem_read = 1'b0;
        vectors++; if ({pc_enable, bus.bus_read} !== 2'b01) begin miscompares++; $display("FAIL lw_next pe/rd got %b/%b want 0/1", pc_enable, bus.bus_read); end
    endtask

    task automatic test_sb();
        pc = 32'hC;
        to_exec(32'h0AA0_0023);
        mem_write = 1'b1;
        address = 32'h203;
        write_to_mem = 32'h0000_00AA;
        data_width = 2'b00;
        bus.bus_rdata = 32'h1234_5678;
        #1;
        vectors++; if (pc_enable !== 1'b0) begin miscompares++; $display("FAIL sb_exec_pe got %b want 0", pc_enable); end
        step();
        vectors++; if ({bus.bus_write, bus.bus_read} !== 2'b10) begin miscompares++; $display("FAIL sb_dir wr/rd got %b/%b want 1/0", bus.bus_write, bus.bus_read); end
        vectors++; if (bus.bus_addr !== 32'h200) begin miscompares++; $display("FAIL sb_addr got %h want 200", bus.bus_addr); end
        vectors++; if (bus.bus_sel !== 4'b1000) begin miscompares++; $display("FAIL sb_sel got %b want 1000", bus.bus_sel); end
        vectors++; if (bus.bus_wdata !== 32'hAA) begin miscompares++; $display("FAIL sb_wdata got %h want aa", bus.bus_wdata); end
        step();
        step();
        vectors++; if (store !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sb_store_kept got %h want deadbeef", store); end
        vectors++; if ({pc_enable, bus.bus_write} !== 2'b10) begin miscompares++; $display("FAIL sb_commit pe/wr got %b/%b want 1/0", pc_enable, bus.bus_write); end
        mem_write = 1'b0;
        step();
    endtask

    task automatic test_sel_table();
        logic [1:0]  dw [6]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [6]  = '{32'h10, 32'h11, 32'h21, 32'h23, 32'h37, 32'h42};
        logic [3:0]  sel [6] = '{4'b0001, 4'b0010, 4'b0011, 4'b1100, 4'hF, 4'hF};
        logic [31:0] wa [6]  = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h34, 32'h40};
        for (int i = 0; i < 6; i++) begin
            to_exec(32'h0000_0023);
            mem_write = 1'b1;
            address = ad[i];
            data_width = dw[i];
            step();
            vectors++; if (bus.bus_sel !== sel[i]) begin miscompares++; $display("FAIL sel_%0d got %b want %b", i, bus.bus_sel, sel[i]); end
            vectors++; if (bus.bus_addr !== wa[i]) begin miscompares++; $display("FAIL sel_addr_%0d got %h want %h", i, bus.bus_addr, wa[i]); end
            step();
            step();
            mem_write = 1'b0;
            step();
        end
    endtask

    task automatic test_priority();
        to_exec(32'h0000_0003);
        mem_read = 1'b1;
        mem_write = 1'b1;
        address = 32'h300;
        write_to_mem = 32'h55;
        data_width = 2'b10;
        bus.bus_rdata = 32'hCAFE_F00D;
        step();
        vectors++; if ({bus.bus_write, bus.bus_read} !== 2'b10) begin miscompares++; $display("FAIL prio wr/rd got %b/%b want 1/0", bus.bus_write, bus.bus_read); end
        step();
        step();
        vectors++; if (store !== 32'hDEAD_BEEF || pc_enable !== 1'b1) begin miscompares++; $display("FAIL prio_commit store/pe got %h/%b want deadbeef/1", store, pc_enable); end
        mem_read = 1'b0;
        mem_write = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        to_exec(32'h1042_A283);
        mem_read = 1'b1;
        address = 32'h104;
        data_width = 2'b10;
        bus.bus_busy = 1'b1;
        step();
        step();
        vectors++; if (bus.bus_read !== 1'b1) begin miscompares++; $display("FAIL mid_pre rd got %b want 1", bus.bus_read); end
        reset = 1'b1;
        #1;
        vectors++; if ({pc_enable, bus.bus_read, bus.bus_write} !== 3'b000) begin miscompares++; $display("FAIL mid_async pe/rd/wr got %b want 000", {pc_enable, bus.bus_read, bus.bus_write}); end
        vectors++; if (instruction !== 32'h13 || store !== 32'h0) begin miscompares++; $display("FAIL mid_regs instr/store got %h/%h want 13/0", instruction, store); end
        step();
        reset = 1'b0;
        mem_read = 1'b0;
        pc = 32'h20;
        step();
        vectors++; if ({bus.bus_read, bus.bus_write} !== 2'b10) begin miscompares++; $display("FAIL mid_refetch rd/wr got %b/%b want 1/0", bus.bus_read, bus.bus_write); end
        vectors++; if (bus.bus_addr !== 32'h20) begin miscompares++; $display("FAIL mid_refetch_addr got %h want 20", bus.bus_addr); end
    endtask

`ifdef REQ_TIMEOUT_EN
    task automatic test_timeout();
        bus.bus_busy = 1'b1;
        bus.bus_rdata = 32'h1111_1111;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if ({bus.bus_read, bus.bus_error} !== 2'b10) begin miscompares++; $display("FAIL to_wait_%0d rd/err got %b/%b want 1/0", k, bus.bus_read, bus.bus_error); end
        end
        step();
        vectors++; if ({bus.bus_read, bus.bus_error, pc_enable} !== 3'b011) begin miscompares++; $display("FAIL to_abort rd/err/pe got %b want 011", {bus.bus_read, bus.bus_error, pc_enable}); end
        vectors++; if (instruction !== 32'h13) begin miscompares++; $display("FAIL to_instr got %h want 13", instruction); end
        bus.bus_busy = 1'b0;
        step();
        vectors++; if ({pc_enable, bus.bus_error} !== 2'b01) begin miscompares++; $display("FAIL to_after pe/err got %b/%b want 0/1", pc_enable, bus.bus_error); end
    endtask
`else
    task automatic test_no_error();
        vectors++; if (bus.bus_error !== 1'b0) begin miscompares++; $display("FAIL no_error got %b want 0", bus.bus_error); end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_lw();
        test_sb();
        test_sel_table();
        test_priority();
        test_reset_mid();
`ifdef REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_error();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
